// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: FSM encoding, opcode map and legality check.
package alu_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_t;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_AND    = 4'b0010;
   localparam logic [3:0] OP_OR     = 4'b0011;
   localparam logic [3:0] OP_XOR    = 4'b0100;
   localparam logic [3:0] OP_NOT    = 4'b0101;
   localparam logic [3:0] OP_SLL    = 4'b0110;
   localparam logic [3:0] OP_SRL    = 4'b0111;
   localparam logic [3:0] OP_SRA    = 4'b1000;
   localparam logic [3:0] OP_SLT    = 4'b1001;
   localparam logic [3:0] OP_PASSA  = 4'b1010;
   localparam logic [3:0] OP_PASSB  = 4'b1011;
   localparam logic [3:0] OP_BPLUS8 = 4'b1100;

   localparam logic [3:0] OP_MAX_LEGAL = OP_BPLUS8;

   function automatic logic op_is_legal(input logic [3:0] op);
      return op <= OP_MAX_LEGAL;
   endfunction

endpackage

// File: rtl/alu_rsp_slot.sv
// One response holding register: captures an ALU result and keeps it until the requester pops it.
module alu_rsp_slot
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] load_out,
   input  logic        load_z,
   input  logic        load_n,
   input  logic        load_err,
   input  logic        rsp_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_out,
   output logic        rsp_z,
   output logic        rsp_n,
   output logic        rsp_err
);

   // A refill on the same edge as a pop wins, so no result is lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_out   <= '0;
         rsp_z     <= 1'b0;
         rsp_n     <= 1'b0;
         rsp_err   <= 1'b0;
      end else if (load) begin
         rsp_valid <= 1'b1;
         rsp_out   <= load_out;
         rsp_z     <= load_z;
         rsp_n     <= load_n;
         rsp_err   <= load_err;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared external combinational ALU.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid_0,
   output logic             req_ready_0,
   input  logic [31:0]      req_a_0,
   input  logic [31:0]      req_b_0,
   input  logic [3:0]       req_op_0,
   input  logic             req_valid_1,
   output logic             req_ready_1,
   input  logic [31:0]      req_a_1,
   input  logic [31:0]      req_b_1,
   input  logic [3:0]       req_op_1,
   output logic             rsp_valid_0,
   input  logic             rsp_ready_0,
   output logic [31:0]      rsp_out_0,
   output logic             rsp_z_0,
   output logic             rsp_n_0,
   output logic             rsp_err_0,
   output logic             rsp_valid_1,
   input  logic             rsp_ready_1,
   output logic [31:0]      rsp_out_1,
   output logic             rsp_z_1,
   output logic             rsp_n_1,
   output logic             rsp_err_1,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [3:0]       alu_op,
   input  logic [31:0]      alu_out,
   input  logic             alu_z,
   input  logic             alu_n,
   output logic [CNT_W-1:0] issue_cnt_0,
   output logic [CNT_W-1:0] issue_cnt_1
);

   state_t state_q, state_d;
   logic   last_grant;
   logic   owner;
   logic   elig_0, elig_1;
   logic   grant_0, grant_1;
   logic   exec_err;
   logic   load_0, load_1;
   logic [31:0] res_out;
   logic        res_z, res_n;

   // A slot that is being popped this cycle counts as free.
   assign elig_0 = req_valid_0 && (!rsp_valid_0 || rsp_ready_0);
   assign elig_1 = req_valid_1 && (!rsp_valid_1 || rsp_ready_1);

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      grant_0 = 1'b0;
      grant_1 = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (elig_0 && elig_1) begin
               grant_0 = last_grant;
               grant_1 = !last_grant;
            end else begin
               grant_0 = elig_0;
               grant_1 = elig_1;
            end
            if (grant_0 || grant_1) state_d = ST_EXEC;
         end
         ST_EXEC: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign req_ready_0 = grant_0 && !reset;
   assign req_ready_1 = grant_1 && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant  <= 1'b1;
         owner       <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= '0;
         issue_cnt_0 <= '0;
         issue_cnt_1 <= '0;
      end else if (req_ready_0) begin
         last_grant  <= 1'b0;
         owner       <= 1'b0;
         alu_a       <= req_a_0;
         alu_b       <= req_b_0;
         alu_op      <= req_op_0;
         issue_cnt_0 <= issue_cnt_0 + 1'b1;
      end else if (req_ready_1) begin
         last_grant  <= 1'b1;
         owner       <= 1'b1;
         alu_a       <= req_a_1;
         alu_b       <= req_b_1;
         alu_op      <= req_op_1;
         issue_cnt_1 <= issue_cnt_1 + 1'b1;
      end
   end

   // Illegal opcodes still occupy an issue slot but return a fixed error result.
   assign exec_err = !op_is_legal(alu_op);
   assign res_out  = exec_err ? 32'd0 : alu_out;
   assign res_z    = exec_err ? 1'b1  : alu_z;
   assign res_n    = exec_err ? 1'b0  : alu_n;

   assign load_0 = (state_q == ST_EXEC) && !owner;
   assign load_1 = (state_q == ST_EXEC) &&  owner;

   alu_rsp_slot u_slot_0 (
      .clk       (clk),
      .reset     (reset),
      .load      (load_0),
      .load_out  (res_out),
      .load_z    (res_z),
      .load_n    (res_n),
      .load_err  (exec_err),
      .rsp_ready (rsp_ready_0),
      .rsp_valid (rsp_valid_0),
      .rsp_out   (rsp_out_0),
      .rsp_z     (rsp_z_0),
      .rsp_n     (rsp_n_0),
      .rsp_err   (rsp_err_0)
   );

   alu_rsp_slot u_slot_1 (
      .clk       (clk),
      .reset     (reset),
      .load      (load_1),
      .load_out  (res_out),
      .load_z    (res_z),
      .load_n    (res_n),
      .load_err  (exec_err),
      .rsp_ready (rsp_ready_1),
      .rsp_valid (rsp_valid_1),
      .rsp_out   (rsp_out_1),
      .rsp_z     (rsp_z_1),
      .rsp_n     (rsp_n_1),
      .rsp_err   (rsp_err_1)
   );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; the bench itself plays the external ALU.
module tb_alu_arbiter;

   logic        clk;
   logic        reset;
   logic        req_valid_0, req_valid_1;
   logic        req_ready_0, req_ready_1;
   logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
   logic [3:0]  req_op_0, req_op_1;
   logic        rsp_valid_0, rsp_valid_1;
   logic        rsp_ready_0, rsp_ready_1;
   logic [31:0] rsp_out_0, rsp_out_1;
   logic        rsp_z_0, rsp_n_0, rsp_err_0;
   logic        rsp_z_1, rsp_n_1, rsp_err_1;
   logic [31:0] alu_a, alu_b, alu_out;
   logic [3:0]  alu_op;
   logic        alu_z, alu_n;
   logic [3:0]  issue_cnt_0, issue_cnt_1;

   int num_checks = 0;
   int num_fails  = 0;

   alu_arbiter #(.CNT_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid_0 (req_valid_0),
      .req_ready_0 (req_ready_0),
      .req_a_0     (req_a_0),
      .req_b_0     (req_b_0),
      .req_op_0    (req_op_0),
      .req_valid_1 (req_valid_1),
      .req_ready_1 (req_ready_1),
      .req_a_1     (req_a_1),
      .req_b_1     (req_b_1),
      .req_op_1    (req_op_1),
      .rsp_valid_0 (rsp_valid_0),
      .rsp_ready_0 (rsp_ready_0),
      .rsp_out_0   (rsp_out_0),
      .rsp_z_0     (rsp_z_0),
      .rsp_n_0     (rsp_n_0),
      .rsp_err_0   (rsp_err_0),
      .rsp_valid_1 (rsp_valid_1),
      .rsp_ready_1 (rsp_ready_1),
      .rsp_out_1   (rsp_out_1),
      .rsp_z_1     (rsp_z_1),
      .rsp_n_1     (rsp_n_1),
      .rsp_err_1   (rsp_err_1),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_op      (alu_op),
      .alu_out     (alu_out),
      .alu_z       (alu_z),
      .alu_n       (alu_n),
      .issue_cnt_0 (issue_cnt_0),
      .issue_cnt_1 (issue_cnt_1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference ALU; unused opcodes return junk so the arbiter's error forcing is visible.
   always_comb begin
      case (alu_op)
         4'd0:    alu_out = alu_a + alu_b;
         4'd1:    alu_out = alu_a - alu_b;
         4'd2:    alu_out = alu_a & alu_b;
         4'd3:    alu_out = alu_a | alu_b;
         4'd4:    alu_out = alu_a ^ alu_b;
         4'd5:    alu_out = ~alu_a;
         4'd6:    alu_out = alu_a << alu_b[4:0];
         4'd7:    alu_out = alu_a >> alu_b[4:0];
         4'd8:    alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         4'd9:    alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
         4'd10:   alu_out = alu_a;
         4'd11:   alu_out = alu_b;
         4'd12:   alu_out = alu_b + 32'd8;
         default: alu_out = 32'hDEAD_BEEF;
      endcase
   end
   assign alu_z = (alu_out == 32'd0);
   assign alu_n = alu_out[31];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic [3:0] op0, input logic v1, input logic [31:0] a1,
                                input logic [31:0] b1, input logic [3:0] op1,
                                input logic rr0, input logic rr1);
      req_valid_0 = v0;
      req_a_0     = a0;
      req_b_0     = b0;
      req_op_0    = op0;
      req_valid_1 = v1;
      req_a_1     = a1;
      req_b_1     = b1;
      req_op_1    = op1;
      rsp_ready_0 = rr0;
      rsp_ready_1 = rr1;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      num_checks++;
      assert (observed === expected)
      else begin
         num_fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1'b1, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
      tick();
      tick();

      $display("[TB] reset state");
      checkOutput("ready0_in_reset", 32'(req_ready_0), 32'd0);
      checkOutput("rsp_valid0_reset", 32'(rsp_valid_0), 32'd0);
      checkOutput("alu_a_reset", alu_a, 32'd0);
      checkOutput("cnt0_reset", 32'(issue_cnt_0), 32'd0);

      $display("[TB] single request 5-3");
      reset = 1'b0;
      applyStimulus(1'b1, 32'd5, 32'd3, 4'd1, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
      checkOutput("single_ready0", 32'(req_ready_0), 32'd1);
      checkOutput("single_ready1", 32'(req_ready_1), 32'd0);
      tick();
      applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
      checkOutput("exec_no_ready", 32'(req_ready_0), 32'd0);
      checkOutput("alu_a_latched", alu_a, 32'd5);
      checkOutput("alu_op_latched", 32'(alu_op), 32'd1);
      checkOutput("rsp_valid0_t1", 32'(rsp_valid_0), 32'd0);
      tick();
      checkOutput("rsp_valid0_t2", 32'(rsp_valid_0), 32'd1);
      checkOutput("rsp_out0_sub", rsp_out_0, 32'd2);
      checkOutput("rsp_z0_sub", 32'(rsp_z_0), 32'd0);
      checkOutput("rsp_n0_sub", 32'(rsp_n_0), 32'd0);
      checkOutput("rsp_err0_sub", 32'(rsp_err_0), 32'd0);
      checkOutput("cnt0_one", 32'(issue_cnt_0), 32'd1);
      tick();
      checkOutput("hold_valid0", 32'(rsp_valid_0), 32'd1);
      checkOutput("hold_out0", rsp_out_0, 32'd2);
      applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
      tick();
      checkOutput("pop_valid0", 32'(rsp_valid_0), 32'd0);

      $display("[TB] alternating grants");
      reset = 1'b1;
      tick();
      reset = 1'b0;
      applyStimulus(1'b1, 32'd10, 32'd4, 4'd0, 1'b1, 32'd7, 32'd7, 4'd1, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("rr_ready0_%0d", i), 32'(req_ready_0), 32'((i % 2) == 0));
         checkOutput($sformatf("rr_ready1_%0d", i), 32'(req_ready_1), 32'((i % 2) == 1));
         tick();
         tick();
         if ((i % 2) == 1) begin
            checkOutput($sformatf("rr_cnt0_%0d", i), 32'(issue_cnt_0), 32'((i + 1) / 2));
            checkOutput($sformatf("rr_cnt1_%0d", i), 32'(issue_cnt_1), 32'((i + 1) / 2));
         end
      end
      checkOutput("rr_valid1", 32'(rsp_valid_1), 32'd1);
      checkOutput("rr_out1", rsp_out_1, 32'd0);
      checkOutput("rr_z1", 32'(rsp_z_1), 32'd1);
      checkOutput("rr_valid0_popped", 32'(rsp_valid_0), 32'd0);
      applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
      tick();

      $display("[TB] blocked slot 0");
      applyStimulus(1'b1, 32'd100, 32'd1, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1);
      checkOutput("fill_ready0", 32'(req_ready_0), 32'd1);
      tick();
      tick();
      applyStimulus(1'b1, 32'd1, 32'd2, 4'd0, 1'b1, 32'h8000_0000, 32'd0, 4'd10, 1'b0, 1'b1);
      checkOutput("blk_ready0_a", 32'(req_ready_0), 32'd0);
      checkOutput("blk_ready1_a", 32'(req_ready_1), 32'd1);
      tick();
      tick();
      checkOutput("blk_out1", rsp_out_1, 32'h8000_0000);
      checkOutput("blk_n1", 32'(rsp_n_1), 32'd1);
      checkOutput("blk_ready0_b", 32'(req_ready_0), 32'd0);
      checkOutput("blk_ready1_b", 32'(req_ready_1), 32'd1);
      tick();
      tick();
      checkOutput("blk_valid0_held", 32'(rsp_valid_0), 32'd1);
      checkOutput("blk_out0_held", rsp_out_0, 32'd101);
      applyStimulus(1'b1, 32'd1, 32'd2, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
      checkOutput("popacc_ready0", 32'(req_ready_0), 32'd1);
      tick();
      checkOutput("popacc_valid0_t1", 32'(rsp_valid_0), 32'd0);
      tick();
      checkOutput("popacc_valid0_t2", 32'(rsp_valid_0), 32'd1);
      checkOutput("popacc_out0", rsp_out_0, 32'd3);
      checkOutput("blk_cnt0", 32'(issue_cnt_0), 32'd4);
      checkOutput("blk_cnt1", 32'(issue_cnt_1), 32'd4);

      $display("[TB] illegal opcode");
      applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd14, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
      checkOutput("ill_ready0", 32'(req_ready_0), 32'd1);
      tick();
      tick();
      checkOutput("ill_valid0", 32'(rsp_valid_0), 32'd1);
      checkOutput("ill_out0", rsp_out_0, 32'd0);
      checkOutput("ill_z0", 32'(rsp_z_0), 32'd1);
      checkOutput("ill_n0", 32'(rsp_n_0), 32'd0);
      checkOutput("ill_err0", 32'(rsp_err_0), 32'd1);
      checkOutput("ill_cnt0", 32'(issue_cnt_0), 32'd5);
      applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
      tick();

      $display("[TB] reset during exec");
      applyStimulus(1'b1, 32'd1, 32'd1, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
      checkOutput("rx_ready0", 32'(req_ready_0), 32'd1);
      tick();
      reset = 1'b1;
      applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
      tick();
      reset = 1'b0;
      #1;
      checkOutput("rx_valid0", 32'(rsp_valid_0), 32'd0);
      checkOutput("rx_valid1", 32'(rsp_valid_1), 32'd0);
      checkOutput("rx_out0", rsp_out_0, 32'd0);
      checkOutput("rx_out1", rsp_out_1, 32'd0);
      checkOutput("rx_err0", 32'(rsp_err_0), 32'd0);
      checkOutput("rx_alu_a", alu_a, 32'd0);
      checkOutput("rx_alu_op", 32'(alu_op), 32'd0);
      checkOutput("rx_cnt0", 32'(issue_cnt_0), 32'd0);
      tick();
      checkOutput("rx_valid0_later", 32'(rsp_valid_0), 32'd0);
      applyStimulus(1'b1, 32'd1, 32'd1, 4'd0, 1'b1, 32'd2, 32'd2, 4'd0, 1'b1, 1'b1);
      checkOutput("rx_first_ready0", 32'(req_ready_0), 32'd1);
      checkOutput("rx_first_ready1", 32'(req_ready_1), 32'd0);
      tick();
      tick();
      checkOutput("rx_out0_after", rsp_out_0, 32'd2);

      $display("[TB] counter wrap");
      applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'd3, 32'd4, 4'd0, 1'b1, 1'b1);
      for (int i = 0; i < 17; i++) begin
         checkOutput($sformatf("wrap_ready1_%0d", i), 32'(req_ready_1), 32'd1);
         tick();
         tick();
      end
      checkOutput("wrap_cnt1", 32'(issue_cnt_1), 32'd1);
      checkOutput("wrap_cnt0", 32'(issue_cnt_0), 32'd1);
      checkOutput("wrap_out1", rsp_out_1, 32'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of per-requester issue counters.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports req_valid_0/1  in  1  requester 0/1 presents an operation.
REQ-005 SHALL have ports req_ready_0/1  out  1  operation accepted this cycle when valid & ready.
REQ-006 SHALL have ports req_a_0/1, req_b_0/1  in  32  operands.
REQ-007 SHALL have ports req_op_0/1  in  4  ALU opcode, 0000..1100 legal.
REQ-008 SHALL have ports rsp_valid_0/1  out  1  result held for requester 0/1.
REQ-009 SHALL have ports rsp_ready_0/1  in  1  requester consumes result when valid & ready.
REQ-010 SHALL have ports rsp_out_0/1  out  32; rsp_z_0/1, rsp_n_0/1, rsp_err_0/1  out  1  result, zero flag, negative flag, illegal-op flag.
REQ-011 SHALL have ports alu_a, alu_b  out  32; alu_op  out  4  registered drive to the shared combinational ALU.
REQ-012 SHALL have ports alu_out  in  32; alu_z, alu_n  in  1  ALU result and flags.
REQ-013 SHALL have ports issue_cnt_0/1  out  CNT_W  accepted-operation counts.

Function
REQ-014 SHALL implement FSM states IDLE and EXEC; IDLE -> EXEC on any acceptance, EXEC -> IDLE unconditionally.
REQ-015 SHALL, in IDLE, treat requester r as eligible when req_valid_r=1 and slot r is empty or being popped this cycle (rsp_valid_r & rsp_ready_r).
REQ-016 SHALL grant round-robin: when both eligible, grant the requester not granted last; last_grant resets to 1 so requester 0 wins first contention.
REQ-017 SHALL assert req_ready_r combinationally only in IDLE and only for the granted requester; never both in one cycle; never in EXEC.
REQ-018 SHALL, on acceptance, latch a, b, op into alu_a/alu_b/alu_op and record owner; alu_* hold value otherwise.
REQ-019 SHALL, in EXEC, capture alu_out, alu_z, alu_n into owner's slot and set rsp_valid_owner=1 at the end of that cycle (accept at edge t -> rsp_valid at t+2).
REQ-020 SHALL, for opcodes 1101..1111, still issue but force rsp_out=0, rsp_z=1, rsp_n=0, rsp_err=1; rsp_err=0 for legal opcodes.
REQ-021 SHALL hold slot contents stable while rsp_valid_r=1 and rsp_ready_r=0; clear rsp_valid_r on pop unless refilled the same edge.
REQ-022 SHALL allow pop of slot r and acceptance from requester r in the same IDLE cycle without loss.
REQ-023 SHALL sustain one operation per 2 cycles; a blocked slot never stalls the other requester.
REQ-024 SHALL increment issue_cnt_r by 1 per acceptance, wrapping modulo 2^CNT_W.

Reset
REQ-025 SHALL, on reset, set FSM=IDLE, last_grant=1, all rsp_valid/out/z/n/err=0, alu_a/alu_b/alu_op=0, issue counters=0.
REQ-026 SHALL, on reset during EXEC, discard the in-flight operation; no rsp_valid afterwards.
REQ-027 SHALL drive req_ready_0/1=0 while reset=1.

Structure
REQ-028 SHALL place FSM state encoding, opcode constants (OP_ADD=0000 .. OP_BPLUS8=1100) and OP_MAX_LEGAL in a shared package alu_pkg.
REQ-029 SHALL implement each response slot as one instantiated sub-module alu_rsp_slot (32-bit data, flags, valid/ready hold register), instantiated twice.
REQ-030 SHALL keep the ALU itself outside this block.

Verification
REQ-031 SHALL cover: req0 only, a=5, b=3, op=0001 -> req_ready_0 in cycle 0, rsp_valid_0 at t+2 with out=2, z=0, n=0.
REQ-032 SHALL cover: both valid every cycle after reset, ready held high -> grants 0,1,0,1; issue_cnt_0=issue_cnt_1 after each pair.
REQ-033 SHALL cover: rsp_ready_0=0 with slot 0 full, both requesting -> only requester 1 granted; result 0 unchanged until popped.
REQ-034 SHALL cover: op=1110, a=b=FFFFFFFF -> rsp_out=0, z=1, n=0, err=1.
REQ-035 SHALL cover: reset asserted in EXEC after accepting a=1, b=1, op=0000 -> no rsp_valid, all outputs 0, next request to requester 0 first.
REQ-036 SHALL cover: CNT_W=4, 17 accepts on requester 1 -> issue_cnt_1=1.
